// File: rtl/vga_pkg.sv
// Default 640x480@60 raster timing and the coordinate/colour types shared by the VGA timing generator.
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_timing_gen_clk_en_div.sv
// Pixel clock-enable divider: pixel_ce is high for one Clk in every CLK_DIV, the first after CLK_DIV-1 edges.
// No handshake; with CLK_DIV=1 the enable is held high whenever reset is released.
module clk_en_div #(
  parameter int CLK_DIV = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic pixel_ce
);

  localparam int            DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q <= '0;
    end else if (div_q == LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // A divide-by-one counter never leaves LAST, so reset must mask the enable explicitly.
  assign pixel_ce = (div_q == LAST) && ((CLK_DIV > 1) || Reset_n);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: DrawX/DrawY counters, sync/blank decode and registered RGB to the DAC.
// hs/vs/blank/VGA_* trail the counters by PIPE_LAT pixel ticks; no backpressure, inputs sampled on pixel_ce.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int CLK_DIV   = 2,
  parameter int PIPE_LAT  = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Red_in,
  input  logic [7:0] Green_in,
  input  logic [7:0] Blue_in,
  output coord_t     DrawX,
  output coord_t     DrawY,
  output logic       pixel_ce,
  output logic       vblank_start,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counters");
    end
    if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be 1..8");
    end
    if (PIPE_LAT < 1 || PIPE_LAT > 4) begin : g_bad_lat
      $error("vga_timing_gen: PIPE_LAT must be 1..4");
    end
  endgenerate

  localparam coord_t X_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t Y_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t Y_VIS_LAST = coord_t'(V_VISIBLE - 1);

  // Decode limits are one bit wider so an end bound of exactly 1024 stays representable.
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic        hs_raw, vs_raw, vis_raw;
  logic [10:0] x_ext, y_ext;
  rgb_t        rgb_in;

  logic [PIPE_LAT-1:0] hs_pipe, vs_pipe, vis_pipe;
  rgb_t                rgb_pipe [PIPE_LAT];

  clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .pixel_ce (pixel_ce)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      DrawX <= '0;
      DrawY <= '0;
    end else if (pixel_ce) begin
      if (DrawX == X_LAST) begin
        DrawX <= '0;
        DrawY <= (DrawY == Y_LAST) ? '0 : DrawY + 1'b1;
      end else begin
        DrawX <= DrawX + 1'b1;
      end
    end
  end

  assign x_ext   = {1'b0, DrawX};
  assign y_ext   = {1'b0, DrawY};
  assign hs_raw  = !((x_ext >= HS_START) && (x_ext < HS_END));
  assign vs_raw  = !((y_ext >= VS_START) && (y_ext < VS_END));
  assign vis_raw = (x_ext < H_VIS) && (y_ext < V_VIS);
  assign rgb_in  = {Red_in, Green_in, Blue_in};

  // Fires on the last tick of the last visible line, i.e. as the raster enters vertical blanking.
  assign vblank_start = pixel_ce && (DrawX == X_LAST) && (DrawY == Y_VIS_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      vis_pipe <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        rgb_pipe[i] <= '0;
      end
    end else if (pixel_ce) begin
      hs_pipe[0]  <= hs_raw;
      vs_pipe[0]  <= vs_raw;
      vis_pipe[0] <= vis_raw;
      rgb_pipe[0] <= vis_raw ? rgb_in : '0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
        vis_pipe[i] <= vis_pipe[i-1];
        rgb_pipe[i] <= rgb_pipe[i-1];
      end
    end
  end

  assign hs    = hs_pipe[PIPE_LAT-1];
  assign vs    = vs_pipe[PIPE_LAT-1];
  assign blank = vis_pipe[PIPE_LAT-1];
  assign sync  = 1'b0;
  assign VGA_R = rgb_pipe[PIPE_LAT-1].r;
  assign VGA_G = rgb_pipe[PIPE_LAT-1].g;
  assign VGA_B = rgb_pipe[PIPE_LAT-1].b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a shrunken-geometry instance for frame-level behaviour.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct packed {
    int hv, hf, hsn, hb, vv, vf, vsn, vb;
  } geom_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        pce;
    logic        vbs;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        sync;
    logic [23:0] rgb;
  } obs_t;

  typedef struct {
    int          c;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        pce;
    logic        hs;
    logic        blank;
    logic [23:0] rgb;
  } vec_t;

  localparam geom_t GA = '{hv: DEF_H_VISIBLE, hf: DEF_H_FRONT, hsn: DEF_H_SYNC, hb: DEF_H_BACK,
                           vv: DEF_V_VISIBLE, vf: DEF_V_FRONT, vsn: DEF_V_SYNC, vb: DEF_V_BACK};
  localparam geom_t GB = '{hv: 20, hf: 3, hsn: 5, hb: 4, vv: 6, vf: 2, vsn: 2, vb: 3};
  localparam int DIV_A = 2, LAT_A = 1;
  localparam int DIV_B = 3, LAT_B = 2;
  localparam obs_t RST_OBS = '{x: 10'd0, y: 10'd0, pce: 1'b0, vbs: 1'b0, hs: 1'b1, vs: 1'b1,
                               blank: 1'b0, sync: 1'b0, rgb: 24'h0};
  localparam int NVEC = 13;

  logic       Clk = 1'b0;
  logic       rst_a, rst_b;
  logic [7:0] red_in, green_in, blue_in;

  logic [9:0] xa, ya, xb, yb;
  logic       pce_a, vbs_a, hs_a, vs_a, blank_a, sync_a;
  logic       pce_b, vbs_b, hs_b, vs_b, blank_b, sync_b;
  logic [7:0] ra, ga, ba, rb, gb, bb;
  obs_t       obs_a, obs_b;

  int          vectors = 0;
  int          miscompares = 0;
  int          vbs_cnt = 0;
  vec_t        tbl [NVEC];
  logic [23:0] capq [$];

  always #5 Clk = ~Clk;

  vga_timing_gen u_dut_a (
    .Clk(Clk), .Reset_n(rst_a), .Red_in(red_in), .Green_in(green_in), .Blue_in(blue_in),
    .DrawX(xa), .DrawY(ya), .pixel_ce(pce_a), .vblank_start(vbs_a), .hs(hs_a), .vs(vs_a),
    .blank(blank_a), .sync(sync_a), .VGA_R(ra), .VGA_G(ga), .VGA_B(ba)
  );

  vga_timing_gen #(
    .H_VISIBLE(GB.hv), .H_FRONT(GB.hf), .H_SYNC(GB.hsn), .H_BACK(GB.hb),
    .V_VISIBLE(GB.vv), .V_FRONT(GB.vf), .V_SYNC(GB.vsn), .V_BACK(GB.vb),
    .CLK_DIV(DIV_B), .PIPE_LAT(LAT_B)
  ) u_dut_b (
    .Clk(Clk), .Reset_n(rst_b), .Red_in(red_in), .Green_in(green_in), .Blue_in(blue_in),
    .DrawX(xb), .DrawY(yb), .pixel_ce(pce_b), .vblank_start(vbs_b), .hs(hs_b), .vs(vs_b),
    .blank(blank_b), .sync(sync_b), .VGA_R(rb), .VGA_G(gb), .VGA_B(bb)
  );

  assign obs_a = {xa, ya, pce_a, vbs_a, hs_a, vs_a, blank_a, sync_a, ra, ga, ba};
  assign obs_b = {xb, yb, pce_b, vbs_b, hs_b, vs_b, blank_b, sync_b, rb, gb, bb};

  function automatic int htot(input geom_t g);
    return g.hv + g.hf + g.hsn + g.hb;
  endfunction

  function automatic int vtot(input geom_t g);
    return g.vv + g.vf + g.vsn + g.vb;
  endfunction

  // Pixel shown by the counters after k ticks since reset release.
  function automatic bit vis_at(input geom_t g, input int k);
    int x = k % htot(g);
    int y = (k / htot(g)) % vtot(g);
    return (x < g.hv) && (y < g.vv);
  endfunction

  // Expected outputs c Clk edges after release: k = c/div ticks elapsed, delayed signals describe tick k-lat.
  function automatic obs_t expect_at(input geom_t g, input int div, input int lat, input int c,
                                     input logic [23:0] rgb);
    obs_t e;
    int   ht = htot(g);
    int   vt = vtot(g);
    int   k  = c / div;
    int   x  = k % ht;
    int   y  = (k / ht) % vt;
    int   px, py;
    e.x    = 10'(x);
    e.y    = 10'(y);
    e.pce  = (c % div) == (div - 1);
    e.vbs  = e.pce && (x == ht - 1) && (y == g.vv - 1);
    e.sync = 1'b0;
    e.rgb  = rgb;
    if (k < lat) begin
      e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0;
    end else begin
      px = (k - lat) % ht;
      py = ((k - lat) / ht) % vt;
      e.hs    = !(px >= g.hv + g.hf && px < g.hv + g.hf + g.hsn);
      e.vs    = !(py >= g.vv + g.vf && py < g.vv + g.vf + g.vsn);
      e.blank = (px < g.hv) && (py < g.vv);
    end
    return e;
  endfunction

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Runs n Clk cycles from reset release, checking every cycle against the model.
  task automatic run(input bit sel_b, input int n, input int const_until);
    geom_t       g   = sel_b ? GB : GA;
    int          div = sel_b ? DIV_B : DIV_A;
    int          lat = sel_b ? LAT_B : LAT_A;
    int          ti  = 0;
    obs_t        got, e;
    logic [23:0] rgb;
    capq.delete();
    for (int i = 0; i < lat; i++) capq.push_back(24'h0);
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge Clk);
      #1;
      got = sel_b ? obs_b : obs_a;
      e   = expect_at(g, div, lat, c, capq[0]);
      cmp($sformatf("raster_%s c=%0d", sel_b ? "b" : "a", c), 64'(got), 64'(e));
      if (got.vbs) vbs_cnt++;
      if (!sel_b && ti < NVEC && tbl[ti].c == c) begin
        cmp($sformatf("vec%0d c=%0d", ti, c),
            64'({got.x, got.y, got.pce, got.hs, got.blank, got.rgb}),
            64'({tbl[ti].x, tbl[ti].y, tbl[ti].pce, tbl[ti].hs, tbl[ti].blank, tbl[ti].rgb}));
        ti++;
      end
      rgb = (c < const_until) ? 24'hFF5500 : 24'($urandom);
      {red_in, green_in, blue_in} = rgb;
      if ((c + 1) % div == 0) begin
        void'(capq.pop_front());
        capq.push_back(vis_at(g, c / div) ? rgb : 24'h0);
      end
    end
  endtask

  initial begin
    // Hand-derived checkpoints for the default mode: CLK_DIV=2, PIPE_LAT=1, FF5500 driven for c<1700.
    tbl[0]  = '{c: 0,    x: 10'd0,   y: 10'd0, pce: 1'b0, hs: 1'b1, blank: 1'b0, rgb: 24'h000000};
    tbl[1]  = '{c: 1,    x: 10'd0,   y: 10'd0, pce: 1'b1, hs: 1'b1, blank: 1'b0, rgb: 24'h000000};
    tbl[2]  = '{c: 2,    x: 10'd1,   y: 10'd0, pce: 1'b0, hs: 1'b1, blank: 1'b1, rgb: 24'hFF5500};
    tbl[3]  = '{c: 3,    x: 10'd1,   y: 10'd0, pce: 1'b1, hs: 1'b1, blank: 1'b1, rgb: 24'hFF5500};
    tbl[4]  = '{c: 1280, x: 10'd640, y: 10'd0, pce: 1'b0, hs: 1'b1, blank: 1'b1, rgb: 24'hFF5500};
    tbl[5]  = '{c: 1282, x: 10'd641, y: 10'd0, pce: 1'b0, hs: 1'b1, blank: 1'b0, rgb: 24'h000000};
    tbl[6]  = '{c: 1312, x: 10'd656, y: 10'd0, pce: 1'b0, hs: 1'b1, blank: 1'b0, rgb: 24'h000000};
    tbl[7]  = '{c: 1314, x: 10'd657, y: 10'd0, pce: 1'b0, hs: 1'b0, blank: 1'b0, rgb: 24'h000000};
    tbl[8]  = '{c: 1504, x: 10'd752, y: 10'd0, pce: 1'b0, hs: 1'b0, blank: 1'b0, rgb: 24'h000000};
    tbl[9]  = '{c: 1506, x: 10'd753, y: 10'd0, pce: 1'b0, hs: 1'b1, blank: 1'b0, rgb: 24'h000000};
    tbl[10] = '{c: 1599, x: 10'd799, y: 10'd0, pce: 1'b1, hs: 1'b1, blank: 1'b0, rgb: 24'h000000};
    tbl[11] = '{c: 1600, x: 10'd0,   y: 10'd1, pce: 1'b0, hs: 1'b1, blank: 1'b0, rgb: 24'h000000};
    tbl[12] = '{c: 1602, x: 10'd1,   y: 10'd1, pce: 1'b0, hs: 1'b1, blank: 1'b1, rgb: 24'hFF5500};

    rst_a = 1'b0;
    rst_b = 1'b0;
    {red_in, green_in, blue_in} = 24'hFF5500;

    repeat (5) begin
      @(negedge Clk);
      #1;
      cmp("reset_a", 64'(obs_a), 64'(RST_OBS));
      cmp("reset_b", 64'(obs_b), 64'(RST_OBS));
    end

    // Default mode: first three lines, constant colour for the first line then random.
    rst_a   = 1'b1;
    vbs_cnt = 0;
    run(1'b0, 3400, 1700);
    cmp("vblank_none_a", 64'(vbs_cnt), 64'd0);
    rst_a = 1'b0;

    // Small mode: run into mid-frame, then abort with an asynchronous reset.
    @(negedge Clk);
    rst_b = 1'b1;
    run(1'b1, 500, 0);
    @(negedge Clk);
    rst_b = 1'b0;
    #1;
    cmp("async_reset_b", 64'(obs_b), 64'(RST_OBS));
    repeat (2) begin
      @(negedge Clk);
      #1;
      cmp("reset_hold_b", 64'(obs_b), 64'(RST_OBS));
    end

    // Three full frames after release: one vblank_start each, never at the frame wrap.
    @(negedge Clk);
    rst_b   = 1'b1;
    vbs_cnt = 0;
    run(1'b1, 3 * htot(GB) * vtot(GB) * DIV_B, 0);
    cmp("vblank_per_frame_b", 64'(vbs_cnt), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
